// File: rtl/seq_checker_pkg.sv
// Shared types and constants for the 3-bit state-sequence checker.
package seq_checker_pkg;

  localparam int unsigned SlotW  = 3;
  localparam int unsigned MaxLen = 8;
  localparam int unsigned SeqW   = SlotW * MaxLen;

  // Slot 0 is the counter's load value; slot i+1 follows slot i.
  localparam logic [SeqW-1:0] DefaultSeq = 24'b000_100_101_111_110_010_011_001;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StTrack  = 2'd2
  } state_e;

  function automatic logic [SlotW-1:0] slot_val(input logic [SeqW-1:0] seq,
                                                input logic [SlotW-1:0] i);
    return seq[i*SlotW +: SlotW];
  endfunction

endpackage

// File: rtl/seq_checker_if.sv
// Sample inputs and status outputs of the sequence checker.
interface seq_checker_if
  import seq_checker_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic             a, b, c;
  logic             anot, bnot, cnot;
  logic             locked;
  logic [SlotW-1:0] idx;
  logic             seq_err;
  logic             comp_err;
  logic             stuck;
  logic             wrap;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] period_cnt;

  modport master (
    output en, a, b, c, anot, bnot, cnot,
    input  locked, idx, seq_err, comp_err, stuck, wrap, err_cnt, period_cnt
  );

  modport slave (
    input  en, a, b, c, anot, bnot, cnot,
    output locked, idx, seq_err, comp_err, stuck, wrap, err_cnt, period_cnt
  );

endinterface

// File: rtl/seq_slot_lookup.sv
// Maps a 3-bit value to the lowest matching slot of the programmed cycle.
module seq_slot_lookup
  import seq_checker_pkg::*;
#(
  parameter int unsigned     SEQ_LEN = 8,
  parameter logic [SeqW-1:0] SEQ     = DefaultSeq
) (
  input  logic [SlotW-1:0] value,
  output logic             hit,
  output logic [SlotW-1:0] slot
);

  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int i = 0; i < int'(MaxLen); i++) begin
      if (!hit && i < int'(SEQ_LEN) && SEQ[i*SlotW +: SlotW] == value) begin
        hit  = 1'b1;
        slot = SlotW'(i);
      end
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Monitors a 3-bit counter: legal successor, complement rails, stuck runs and periods.
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int unsigned     SEQ_LEN   = 8,
  parameter logic [SeqW-1:0] SEQ       = DefaultSeq,
  parameter int unsigned     STUCK_MAX = 4,
  parameter int unsigned     CNT_W     = 8
) (
  input logic         clk,
  input logic         rst,
  seq_checker_if.slave bus
);

  localparam int unsigned      RunW    = $clog2(STUCK_MAX + 1);
  localparam logic [SlotW-1:0] LastIdx = SlotW'(SEQ_LEN - 1);

  state_e             state_q, state_d;
  logic [SlotW-1:0]   idx_q, idx_d;
  logic               locked_q;
  logic               seq_err_q, seq_err_d;
  logic               comp_err_q, comp_err_d;
  logic               stuck_q, stuck_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [RunW-1:0]    run_q, run_d;
  logic [SlotW-1:0]   prev_q;

  logic [SlotW-1:0]   s, cur_val, nxt_idx, exp_val, sample_slot, exp_slot;
  logic               sample_hit, exp_hit;

  assign s       = {bus.a, bus.b, bus.c};
  assign cur_val = slot_val(SEQ, idx_q);
  assign nxt_idx = (idx_q == LastIdx) ? '0 : idx_q + SlotW'(1);
  assign exp_val = slot_val(SEQ, nxt_idx);

  seq_slot_lookup #(.SEQ_LEN(SEQ_LEN), .SEQ(SEQ)) u_sample_lookup (
    .value (s),
    .hit   (sample_hit),
    .slot  (sample_slot)
  );

  seq_slot_lookup #(.SEQ_LEN(SEQ_LEN), .SEQ(SEQ)) u_expected_lookup (
    .value (exp_val),
    .hit   (exp_hit),
    .slot  (exp_slot)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_err_d    = 1'b0;
    wrap_d       = 1'b0;
    err_cnt_d    = err_cnt_q;
    period_cnt_d = period_cnt_q;
    case (state_q)
      StIdle, StSearch: begin
        if (sample_hit) begin
          state_d = StTrack;
          idx_d   = sample_slot;
        end else begin
          state_d = StSearch;
        end
      end
      StTrack: begin
        if (exp_hit && s == exp_val) begin
          idx_d = exp_slot;
          if (idx_q == LastIdx) begin
            wrap_d = 1'b1;
            if (period_cnt_q != '1) period_cnt_d = period_cnt_q + CNT_W'(1);
          end
        end else if (s != cur_val) begin
          seq_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (sample_hit) idx_d = sample_slot;
          else            state_d = StSearch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // run_q == 0 marks "no sample since reset", so a first 000 sample is not a repeat.
  always_comb begin
    run_d = run_q;
    if (run_q == '0 || s != prev_q) run_d = RunW'(1);
    else if (run_q < RunW'(STUCK_MAX)) run_d = run_q + RunW'(1);
    stuck_d    = (run_d == RunW'(STUCK_MAX));
    comp_err_d = ({bus.anot, bus.bnot, bus.cnot} != ~s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      locked_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      comp_err_q   <= 1'b0;
      stuck_q      <= 1'b0;
      wrap_q       <= 1'b0;
      err_cnt_q    <= '0;
      period_cnt_q <= '0;
      run_q        <= '0;
      prev_q       <= '0;
    end else if (bus.en) begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      locked_q     <= (state_d == StTrack);
      seq_err_q    <= seq_err_d;
      comp_err_q   <= comp_err_d;
      stuck_q      <= stuck_d;
      wrap_q       <= wrap_d;
      err_cnt_q    <= err_cnt_d;
      period_cnt_q <= period_cnt_d;
      run_q        <= run_d;
      prev_q       <= s;
    end else begin
      seq_err_q  <= 1'b0;
      comp_err_q <= 1'b0;
      wrap_q     <= 1'b0;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.idx        = idx_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.comp_err   = comp_err_q;
  assign bus.stuck      = stuck_q;
  assign bus.wrap       = wrap_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.period_cnt = period_cnt_q;

endmodule

// File: tb/tb_seq_checker.sv
// Randomised and directed bench for seq_checker against a behavioural model.
module tb_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  seq_checker_if #(.CNT_W(8)) bus1 ();
  seq_checker_if #(.CNT_W(8)) bus2 ();

  seq_checker u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  seq_checker #(
    .SEQ_LEN   (3),
    .SEQ       (24'b000_000_000_000_000_100_010_001),
    .STUCK_MAX (4),
    .CNT_W     (8)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Legal cycle as a plain list of values, slot 0 first.
  logic [2:0] seqv [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  localparam int Len = 8;
  localparam int StuckMax = 4;

  bit         m_track;
  int         m_idx, m_err, m_per, m_run;
  logic [2:0] m_prev;
  bit         m_have;
  bit         e_seq_err, e_comp_err, e_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int find_slot(input logic [2:0] v);
    for (int i = 0; i < Len; i++) if (seqv[i] == v) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_track = 0; m_idx = 0; m_err = 0; m_per = 0; m_run = 0; m_prev = 3'b000; m_have = 0;
    e_seq_err = 0; e_comp_err = 0; e_wrap = 0;
  endtask

  task automatic model_step(input bit en, input logic [2:0] s, input logic [2:0] cm);
    int pos;
    e_seq_err = 0; e_comp_err = 0; e_wrap = 0;
    if (!en) return;
    pos = find_slot(s);
    e_comp_err = (cm != ~s);
    if (!m_track) begin
      if (pos >= 0) begin m_track = 1; m_idx = pos; end
    end else if (s == seqv[(m_idx + 1) % Len]) begin
      if (m_idx == Len - 1) begin e_wrap = 1; if (m_per < 255) m_per++; end
      m_idx = (m_idx + 1) % Len;
    end else if (s != seqv[m_idx]) begin
      e_seq_err = 1;
      if (m_err < 255) m_err++;
      if (pos >= 0) m_idx = pos; else m_track = 0;
    end
    if (!m_have || s != m_prev) m_run = 1;
    else if (m_run < StuckMax) m_run++;
    m_prev = s; m_have = 1;
  endtask

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clk) begin
    chk("locked",     32'(bus1.locked),     32'(m_track));
    chk("idx",        32'(bus1.idx),        32'(m_idx));
    chk("seq_err",    32'(bus1.seq_err),    32'(e_seq_err));
    chk("comp_err",   32'(bus1.comp_err),   32'(e_comp_err));
    chk("wrap",       32'(bus1.wrap),       32'(e_wrap));
    chk("stuck",      32'(bus1.stuck),      32'(m_run == StuckMax));
    chk("err_cnt",    32'(bus1.err_cnt),    32'(m_err));
    chk("period_cnt", 32'(bus1.period_cnt), 32'(m_per));
  end

  task automatic step(input bit en, input logic [2:0] s, input logic [2:0] cm);
    @(negedge clk);
    #1;
    bus1.en = en;
    {bus1.a, bus1.b, bus1.c} = s;
    {bus1.anot, bus1.bnot, bus1.cnot} = cm;
    bus2.en = 1'b0;
    model_step(en, s, cm);
    @(posedge clk);
    #1;
  endtask

  task automatic good(input logic [2:0] s);
    step(1'b1, s, ~s);
  endtask

  task automatic step2(input logic [2:0] s);
    @(negedge clk);
    #1;
    bus2.en = 1'b1;
    {bus2.a, bus2.b, bus2.c} = s;
    {bus2.anot, bus2.bnot, bus2.cnot} = ~s;
    bus1.en = 1'b0;
    model_step(1'b0, s, ~s);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus1.en = 1'b0;
    bus2.en = 1'b0;
    #1;
    chk("rst_locked",  32'(bus1.locked),  0);
    chk("rst_idx",     32'(bus1.idx),     0);
    chk("rst_err_cnt", 32'(bus1.err_cnt), 0);
    chk("rst_seq_err", 32'(bus1.seq_err), 0);
    chk("rst_stuck",   32'(bus1.stuck),   0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] walk [8];
    logic [2:0] s, cm;
    int r;
    walk = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    bus1.en = 0; bus1.a = 0; bus1.b = 0; bus1.c = 0; bus1.anot = 1; bus1.bnot = 1; bus1.cnot = 1;
    bus2.en = 0; bus2.a = 0; bus2.b = 0; bus2.c = 0; bus2.anot = 1; bus2.bnot = 1; bus2.cnot = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Three-slot cycle: illegal values search silently, then lock and wrap.
    step2(3'b111); chk("s3_locked_a", 32'(bus2.locked), 0); chk("s3_seqerr_a", 32'(bus2.seq_err), 0);
    step2(3'b111); chk("s3_locked_b", 32'(bus2.locked), 0); chk("s3_seqerr_b", 32'(bus2.seq_err), 0);
    step2(3'b010); chk("s3_locked_c", 32'(bus2.locked), 1); chk("s3_idx_c", 32'(bus2.idx), 1);
    step2(3'b100); chk("s3_idx_d", 32'(bus2.idx), 2); chk("s3_wrap_d", 32'(bus2.wrap), 0);
    step2(3'b001); chk("s3_idx_e", 32'(bus2.idx), 0); chk("s3_wrap_e", 32'(bus2.wrap), 1);

    // Full legal period.
    good(3'b001); chk("lit_locked0", 32'(bus1.locked), 1); chk("lit_idx0", 32'(bus1.idx), 0);
    for (int i = 1; i < 8; i++) good(walk[i]);
    chk("lit_idx7", 32'(bus1.idx), 7);
    good(3'b001);
    chk("lit_wrap", 32'(bus1.wrap), 1);
    chk("lit_period", 32'(bus1.period_cnt), 1);
    chk("lit_err0", 32'(bus1.err_cnt), 0);

    // Illegal successor resynchronises.
    good(3'b011); good(3'b010); good(3'b111);
    chk("lit_seq_err", 32'(bus1.seq_err), 1);
    chk("lit_err1", 32'(bus1.err_cnt), 1);
    chk("lit_idx4", 32'(bus1.idx), 4);
    chk("lit_locked1", 32'(bus1.locked), 1);

    // Walk to 110 then hold it until stuck.
    for (int i = 5; i < 8; i++) good(walk[i]);
    for (int i = 0; i < 4; i++) good(walk[i]);
    good(3'b110); good(3'b110);
    chk("lit_stuck_early", 32'(bus1.stuck), 0);
    good(3'b110);
    chk("lit_stuck", 32'(bus1.stuck), 1);
    chk("lit_stuck_noerr", 32'(bus1.seq_err), 0);
    good(3'b111);
    chk("lit_unstuck", 32'(bus1.stuck), 0);
    chk("lit_idx_after", 32'(bus1.idx), 4);

    // Broken complement rails on a legal step.
    step(1'b1, 3'b101, 3'b000);
    chk("lit_comp_err", 32'(bus1.comp_err), 1);
    chk("lit_comp_idx", 32'(bus1.idx), 5);
    good(3'b100);
    chk("lit_comp_clear", 32'(bus1.comp_err), 0);

    // Random traffic: mostly successors, some holds, some jumps and bad rails.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (m_track && r < 60) s = seqv[(m_idx + 1) % Len];
      else if (r < 75)       s = m_prev;
      else                   s = 3'($urandom_range(0, 7));
      cm = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : ~s;
      step(($urandom_range(0, 9) != 0), s, cm);
    end

    // Mid-operation asynchronous reset with five errors on the books.
    async_reset();
    good(3'b001);
    for (int i = 0; i < 5; i++) good((i % 2 == 0) ? 3'b010 : 3'b001);
    chk("lit_err5", 32'(bus1.err_cnt), 5);
    async_reset();
    good(3'b010);
    chk("lit_relock", 32'(bus1.locked), 1);
    chk("lit_relock_idx", 32'(bus1.idx), 2);
    chk("lit_relock_noerr", 32'(bus1.seq_err), 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) good((i % 2 == 0) ? 3'b001 : 3'b010);
    chk("lit_err_sat", 32'(bus1.err_cnt), 255);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Downstream monitor for the 3-bit state counter. Samples its true outputs (a,b,c) and complement outputs (anot,bnot,cnot) on every enabled clock edge.
- Checks each sample against a programmed legal state cycle and verifies that every complement rail is the inverse of its true rail.
- Reports lock, sequence errors, stuck states and completed periods to the bench or to higher-level status logic.

Parameters:
- SEQ_LEN, 8, number of states in the legal cycle (2..8).
- SEQ, 24'b000_100_101_111_110_010_011_001, packed legal cycle; slot i = SEQ[3*i+2:3*i], slot 0 = 3'b001 (the counter's load value), slot i+1 is the successor of slot i, and the successor of slot SEQ_LEN-1 is slot 0.
- STUCK_MAX, 4, number of consecutive identical samples that flags a stuck state (>=2).
- CNT_W, 8, width of the saturating counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable; no state change when 0.
- a, b, c  input  1 each  counter state bits; sample value s = {a,b,c}.
- anot, bnot, cnot  input  1 each  counter complement bits.
- locked  output  1  high while in TRACK.
- idx  output  3  slot index of the last accepted sample.
- seq_err  output  1  one-cycle pulse on an illegal successor.
- comp_err  output  1  one-cycle pulse on a complement mismatch.
- stuck  output  1  level; high while the current run of identical samples is >= STUCK_MAX.
- wrap  output  1  one-cycle pulse when the sequence re-enters slot 0 from slot SEQ_LEN-1.
- err_cnt  output  CNT_W  saturating count of seq_err events.
- period_cnt  output  CNT_W  saturating count of wrap events.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - State goes to IDLE.
  - locked, seq_err, comp_err, stuck and wrap go to 0.
  - idx, err_cnt, period_cnt and the run counter go to 0.
- All outputs are registered and update on the same posedge that captures a sample (en=1). With en=0, registers hold and pulses drop to 0.
- Slot lookup: the slot match is the lowest i < SEQ_LEN with SEQ slot i == s. A value not present in SEQ is "illegal".
- FSM states:
  - IDLE: on the first enabled edge, a legal s moves to TRACK with idx = its slot and locked = 1. An illegal s moves to SEARCH.
  - SEARCH: locked = 0. The first legal s moves to TRACK. An illegal s stays in SEARCH and raises no seq_err.
  - TRACK:
    - Expected value e = slot (idx+1) mod SEQ_LEN.
    - s == e: idx advances. If the old idx was SEQ_LEN-1, pulse wrap and increment period_cnt.
    - s == current slot value: hold, counts toward stuck, no seq_err.
    - Any other value: pulse seq_err and increment err_cnt. A legal s resynchronises idx and stays in TRACK; an illegal s goes to SEARCH with locked = 0.
- comp_err:
  - Evaluated on every enabled edge in every state: pulse if {anot,bnot,cnot} != ~{a,b,c}.
  - Independent of the FSM; a sample with comp_err is still processed as above.
- stuck:
  - The run counter resets to 1 when s differs from the previous sample and saturates at STUCK_MAX.
  - stuck is 1 while the run counter == STUCK_MAX.
  - The previous-sample register is cleared on reset; the first sample sets the run counter to 1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous events: seq_err, comp_err and stuck may assert on the same edge. wrap and seq_err are mutually exclusive.
- SEQ must hold distinct values; duplicate slots are a configuration error and are not checked in RTL.

Decomposition:
- Shared header seq_checker_defs.vh holds:
  - state encodings IDLE=2'd0, SEARCH=2'd1, TRACK=2'd2;
  - the default SEQ constant;
  - the slot field width (3).
- One sub-module, seq_slot_lookup: combinational; maps a 3-bit value to {hit, slot} given SEQ and SEQ_LEN. It is instantiated twice: once for the sample, once for the expected successor.

Test Plan:
- Reset then en=1, drive 001,011,010,110,111,101,100,000,001 with correct complements -> locked=1 from the first edge, idx 0..7..0, wrap pulses once on the ninth sample, period_cnt=1, err_cnt=0.
- In TRACK at idx=2 (010), drive 111 -> seq_err pulse, err_cnt=1, idx=4, locked stays 1.
- Drive 110 four times in TRACK -> stuck=1 on the fourth edge, no seq_err; then drive 111 -> stuck=0, idx advances.
- Drive a=1,b=0,c=1 with anot=0,bnot=0,cnot=0 -> comp_err pulses for that single cycle; FSM processes 101 normally.
- SEQ_LEN=3 with SEQ slots 001,010,100; drive 111,111,010 -> SEARCH (locked=0, no seq_err) on 111, then TRACK with idx=1 on 010.
- Assert rst asynchronously between edges while in TRACK with err_cnt=5 -> all outputs 0 immediately; the next legal sample after deassert relocks from IDLE.
- Force 300 illegal transitions -> err_cnt saturates at 255.
